calc2_top_core: RTL and testbench

CALC2_TOP_CORE -- requirements
Module: calc2_top

---
 rtl/calc2_top_core.sv | 279 +++++++++++++++++++++++++++
 tb/tb_calc2_top_core.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_top_core.sv
// calc2_top_core: four request ports with a two-cycle command/operand protocol.
// Each port has a pending-request queue. One add/sub unit and one shift unit are
// shared between the ports and arbitrated round-robin. Invalid commands bypass the
// units. Results pass through one result register and one output register.
module calc2_top_core #(
  parameter int unsigned QDEPTH = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req4_tag_in,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_tag1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_tag2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_tag3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic [1:0]  out_tag4
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_OVF = 2'd2;
  localparam logic [1:0] RESP_BAD = 2'd3;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } req_t;

  typedef enum logic [1:0] {
    UNIT_ADDSUB,
    UNIT_SHIFT,
    UNIT_NONE
  } unit_t;

  typedef enum logic {
    CAP_CMD,
    CAP_OP2
  } cap_t;

  function automatic unit_t unit_of(input logic [3:0] cmd);
    unit_t u;
    u = UNIT_NONE;
    case (cmd)
      CMD_ADD, CMD_SUB: u = UNIT_ADDSUB;
      CMD_SHL, CMD_SHR: u = UNIT_SHIFT;
      default:          u = UNIT_NONE;
    endcase
    return u;
  endfunction

  // Returns {resp, data}; data is forced to zero on every non-success response.
  function automatic logic [33:0] execute(input req_t r);
    logic [32:0] sum;
    logic [33:0] res;
    sum = {1'b0, r.op1} + {1'b0, r.op2};
    res = {RESP_BAD, 32'd0};
    case (r.cmd)
      CMD_ADD: res = sum[32] ? {RESP_OVF, 32'd0} : {RESP_OK, sum[31:0]};
      CMD_SUB: res = (r.op2 > r.op1) ? {RESP_OVF, 32'd0} : {RESP_OK, r.op1 - r.op2};
      CMD_SHL: res = {RESP_OK, r.op1 << r.op2[4:0]};
      CMD_SHR: res = {RESP_OK, r.op1 >> r.op2[4:0]};
      default: res = {RESP_BAD, 32'd0};
    endcase
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
    return (v == PW'(QDEPTH - 1)) ? '0 : v + PW'(1);
  endfunction

  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];
  logic [1:0]  tag_in  [4];

  logic [3:0]  has_head;
  req_t        head [4];
  logic [3:0]  pop;

  logic [1:0]  o_resp_a [4];
  logic [31:0] o_data_a [4];
  logic [1:0]  o_tag_a  [4];

  logic [1:0]  rr_as, rr_as_nx;
  logic [1:0]  rr_sh, rr_sh_nx;

  // Gather the named ports into indexable arrays.
  always_comb begin
    cmd_in[0]  = req1_cmd_in;  data_in[0] = req1_data_in; tag_in[0] = req1_tag_in;
    cmd_in[1]  = req2_cmd_in;  data_in[1] = req2_data_in; tag_in[1] = req2_tag_in;
    cmd_in[2]  = req3_cmd_in;  data_in[2] = req3_data_in; tag_in[2] = req3_tag_in;
    cmd_in[3]  = req4_cmd_in;  data_in[3] = req4_data_in; tag_in[3] = req4_tag_in;
  end

  // Drive the named output ports from the per-port output registers.
  always_comb begin
    out_resp1 = o_resp_a[0]; out_data1 = o_data_a[0]; out_tag1 = o_tag_a[0];
    out_resp2 = o_resp_a[1]; out_data2 = o_data_a[1]; out_tag2 = o_tag_a[1];
    out_resp3 = o_resp_a[2]; out_data3 = o_data_a[2]; out_tag3 = o_tag_a[2];
    out_resp4 = o_resp_a[3]; out_data4 = o_data_a[3]; out_tag4 = o_tag_a[3];
  end

  for (genvar p = 0; p < 4; p++) begin : g_port
    cap_t            st, st_nx;
    logic            wr_en;
    logic [3:0]      h_cmd;
    logic [31:0]     h_op1;
    logic [1:0]      h_tag;
    req_t            mem [QDEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt;
    logic [1:0]      res_resp, res_tag;
    logic [31:0]     res_data;
    logic [1:0]      o_resp, o_tag;
    logic [31:0]     o_data;

    // Capture state register: command cycle vs operand-2 cycle.
    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) st <= CAP_CMD;
      else        st <= st_nx;
    end

    // Next capture state; the operand-2 cycle completes the request and writes
    // it unless the queue is already full, in which case it is dropped.
    always_comb begin
      st_nx = st;
      wr_en = 1'b0;
      unique case (st)
        CAP_CMD: if (cmd_in[p] != 4'd0) st_nx = CAP_OP2;
        CAP_OP2: begin
          st_nx = CAP_CMD;
          wr_en = (cnt != CW'(QDEPTH));
        end
      endcase
    end

    // Hold command, operand 1 and tag until operand 2 arrives.
    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        h_cmd <= '0;
        h_op1 <= '0;
        h_tag <= '0;
      end else if (st == CAP_CMD && cmd_in[p] != 4'd0) begin
        h_cmd <= cmd_in[p];
        h_op1 <= data_in[p];
        h_tag <= tag_in[p];
      end
    end

    // Queue storage; contents are meaningless once pointers/count are reset.
    always_ff @(posedge c_clk) begin
      if (wr_en) mem[wptr] <= {h_cmd, h_op1, data_in[p], h_tag};
    end

    // Queue pointers and occupancy.
    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (wr_en)  wptr <= ptr_inc(wptr);
        if (pop[p]) rptr <= ptr_inc(rptr);
        case ({wr_en, pop[p]})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    assign has_head[p] = (cnt != '0);
    assign head[p]     = mem[rptr];

    // Result register: computed in the cycle the head is granted and popped.
    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        res_resp <= '0;
        res_data <= '0;
        res_tag  <= '0;
      end else if (pop[p]) begin
        {res_resp, res_data} <= execute(head[p]);
        res_tag              <= head[p].tag;
      end else begin
        res_resp <= '0;
        res_data <= '0;
        res_tag  <= '0;
      end
    end

    // Output register: presents each result for exactly one cycle.
    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        o_resp <= '0;
        o_data <= '0;
        o_tag  <= '0;
      end else begin
        o_resp <= res_resp;
        o_data <= res_data;
        o_tag  <= res_tag;
      end
    end

    assign o_resp_a[p] = o_resp;
    assign o_data_a[p] = o_data;
    assign o_tag_a[p]  = o_tag;
  end

  // Dispatch: invalid heads always pop; each unit grants the first candidate
  // at or after its pointer, and the pointer moves to the port after the grant.
  always_comb begin
    logic [1:0] idx;
    logic       as_found;
    logic       sh_found;
    idx      = '0;
    as_found = 1'b0;
    sh_found = 1'b0;
    pop      = '0;
    rr_as_nx = rr_as;
    rr_sh_nx = rr_sh;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = 2'(i);
      if (has_head[idx] && unit_of(head[idx].cmd) == UNIT_NONE) pop[idx] = 1'b1;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_as + 2'(i);
      if (!as_found && has_head[idx] && unit_of(head[idx].cmd) == UNIT_ADDSUB) begin
        pop[idx] = 1'b1;
        as_found = 1'b1;
        rr_as_nx = idx + 2'd1;
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_sh + 2'(i);
      if (!sh_found && has_head[idx] && unit_of(head[idx].cmd) == UNIT_SHIFT) begin
        pop[idx] = 1'b1;
        sh_found = 1'b1;
        rr_sh_nx = idx + 2'd1;
      end
    end
  end

  // Round-robin pointers, starting at port 1 after reset.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_as <= '0;
      rr_sh <= '0;
    end else begin
      rr_as <= rr_as_nx;
      rr_sh <= rr_sh_nx;
    end
  end

endmodule

// File: tb/tb_calc2_top_core.sv
// tb_calc2_top_core: directed and random requests on four ports; a queue-based
// reference model predicts each response and its cycle, a monitor compares.
module tb_calc2_top_core;

  localparam int unsigned QD = 4;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cmd_d  [4];
  logic [31:0] data_d [4];
  logic [1:0]  tag_d  [4];
  logic [1:0]  resp_o [4];
  logic [31:0] dat_o  [4];
  logic [1:0]  tag_o  [4];

  calc2_top_core #(.QDEPTH(QD)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd_d[0]), .req1_data_in(data_d[0]), .req1_tag_in(tag_d[0]),
    .req2_cmd_in(cmd_d[1]), .req2_data_in(data_d[1]), .req2_tag_in(tag_d[1]),
    .req3_cmd_in(cmd_d[2]), .req3_data_in(data_d[2]), .req3_tag_in(tag_d[2]),
    .req4_cmd_in(cmd_d[3]), .req4_data_in(data_d[3]), .req4_tag_in(tag_d[3]),
    .out_resp1(resp_o[0]), .out_data1(dat_o[0]), .out_tag1(tag_o[0]),
    .out_resp2(resp_o[1]), .out_data2(dat_o[1]), .out_tag2(tag_o[1]),
    .out_resp3(resp_o[2]), .out_data3(dat_o[2]), .out_tag3(tag_o[2]),
    .out_resp4(resp_o[3]), .out_data4(dat_o[3]), .out_tag4(tag_o[3])
  );

  always #5 c_clk = ~c_clk;

  typedef struct { logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2; logic [1:0] tag; } mreq_t;
  typedef struct { logic [1:0] resp; logic [31:0] data; logic [1:0] tag; int unsigned due; } exp_t;
  typedef struct { logic [3:0] cmd; logic [31:0] data; logic [1:0] tag; } drv_t;

  mreq_t       mq   [4][$];
  exp_t        expq [4][$];
  drv_t        drvq [4][$];
  bit          m_pend [4];
  mreq_t       m_half [4];
  int unsigned rr_as = 0;
  int unsigned rr_sh = 0;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s port%0d got=%0h want=%0h cycle=%0d", nm, p + 1, act, req, cyc);
    end
  endtask

  function automatic void ref_result(input mreq_t r, output logic [1:0] rsp, output logic [31:0] dat);
    longint unsigned a, b;
    a = longint'(r.op1);
    b = longint'(r.op2);
    rsp = 2'd3;
    dat = 32'd0;
    case (r.cmd)
      4'd1: if (a + b > 64'hFFFF_FFFF) rsp = 2'd2; else begin rsp = 2'd1; dat = 32'(a + b); end
      4'd2: if (b > a) rsp = 2'd2; else begin rsp = 2'd1; dat = 32'(a - b); end
      4'd5: begin rsp = 2'd1; dat = r.op1 << (r.op2 % 32); end
      4'd6: begin rsp = 2'd1; dat = r.op1 >> (r.op2 % 32); end
      default: begin rsp = 2'd3; dat = 32'd0; end
    endcase
  endfunction

  function automatic bit is_as(input logic [3:0] c); return c == 4'd1 || c == 4'd2; endfunction
  function automatic bit is_sh(input logic [3:0] c); return c == 4'd5 || c == 4'd6; endfunction

  // Reference model: per-port request queues, round-robin grant per unit,
  // response due one edge after the pop.
  always @(posedge c_clk) begin : model
    int unsigned sz [4];
    bit          popd [4];
    int unsigned pp;
    bit          found;
    mreq_t       e;
    logic [1:0]  rsp;
    logic [31:0] dat;
    cyc++;
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        mq[p].delete();
        expq[p].delete();
        m_pend[p] = 1'b0;
      end
      rr_as = 0;
      rr_sh = 0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        sz[p]   = mq[p].size();
        popd[p] = (sz[p] > 0) && !is_as(mq[p][0].cmd) && !is_sh(mq[p][0].cmd);
      end
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        pp = (rr_as + i) % 4;
        if (!found && sz[pp] > 0 && is_as(mq[pp][0].cmd)) begin
          popd[pp] = 1'b1; found = 1'b1; rr_as = (pp + 1) % 4;
        end
      end
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        pp = (rr_sh + i) % 4;
        if (!found && sz[pp] > 0 && is_sh(mq[pp][0].cmd)) begin
          popd[pp] = 1'b1; found = 1'b1; rr_sh = (pp + 1) % 4;
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (popd[p]) begin
          e = mq[p].pop_front();
          ref_result(e, rsp, dat);
          expq[p].push_back('{rsp, dat, e.tag, cyc + 1});
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (m_pend[p]) begin
          m_half[p].op2 = data_d[p];
          if (sz[p] < QD) mq[p].push_back(m_half[p]);
          m_pend[p] = 1'b0;
        end else if (cmd_d[p] != 4'd0) begin
          m_pend[p] = 1'b1;
          m_half[p] = '{cmd_d[p], data_d[p], 32'd0, tag_d[p]};
        end
      end
    end
  end

  // Monitor: compares what each port presents against the expected queue.
  always @(negedge c_clk) begin : monitor
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      if (!reset) begin
        chk("rst_resp", p, 32'(resp_o[p]), 32'd0);
        chk("rst_data", p, dat_o[p], 32'd0);
        chk("rst_tag", p, 32'(tag_o[p]), 32'd0);
        expq[p].delete();
      end else if (resp_o[p] != 2'd0) begin
        if (expq[p].size() == 0) begin
          chk("unexpected", p, 32'(resp_o[p]), 32'd0);
        end else begin
          e = expq[p].pop_front();
          chk("resp", p, 32'(resp_o[p]), 32'(e.resp));
          chk("data", p, dat_o[p], e.data);
          chk("tag", p, 32'(tag_o[p]), 32'(e.tag));
          chk("latency", p, cyc, e.due);
        end
      end else begin
        chk("idle_data", p, dat_o[p], 32'd0);
        chk("idle_tag", p, 32'(tag_o[p]), 32'd0);
        if (expq[p].size() > 0 && expq[p][0].due <= cyc) begin
          e = expq[p].pop_front();
          chk("missing", p, 32'(resp_o[p]), 32'(e.resp));
        end
      end
    end
  end

  // Driver: one protocol beat per port per cycle, idle beats carry cmd 0.
  initial begin : driver
    drv_t d;
    for (int p = 0; p < 4; p++) begin
      cmd_d[p] = 4'd0; data_d[p] = 32'd0; tag_d[p] = 2'd0;
    end
    forever begin
      @(posedge c_clk);
      #2;
      for (int p = 0; p < 4; p++) begin
        if (drvq[p].size() > 0) begin
          d = drvq[p].pop_front();
          cmd_d[p] = d.cmd; data_d[p] = d.data; tag_d[p] = d.tag;
        end else begin
          cmd_d[p] = 4'd0; data_d[p] = $urandom; tag_d[p] = 2'($urandom);
        end
      end
    end
  end

  // The operand-2 beat carries a random cmd, which the design must ignore.
  task automatic issue(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                       input logic [31:0] op2, input logic [1:0] tag);
    drvq[p].push_back('{cmd, op1, tag});
    if (cmd != 4'd0) drvq[p].push_back('{4'($urandom), op2, 2'($urandom)});
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = 1'b1;
    for (int p = 0; p < 4; p++)
      if (drvq[p].size() != 0 || mq[p].size() != 0 || expq[p].size() != 0 || m_pend[p]) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_idle(input string nm);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(posedge c_clk);
      #3;
      idle = all_idle();
    end
    tests++;
    if (!idle) begin
      fails++;
      $display("FAIL drain_%s got=busy want=idle cycle=%0d", nm, cyc);
    end
  endtask

  function automatic logic [3:0] rand_cmd();
    case ($urandom % 8)
      0: return 4'd0;
      1, 6: return 4'd1;
      2, 7: return 4'd2;
      3: return 4'd5;
      4: return 4'd6;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin : main
    logic [31:0] a;
    #1 reset = 1'b0;
    repeat (3) @(posedge c_clk);
    #2 reset = 1'b1;
    @(posedge c_clk); #3;

    issue(0, 4'd1, 32'h30, 32'h20, 2'd1);
    wait_idle("add");

    issue(1, 4'd2, 32'h10, 32'h20, 2'd0);
    issue(2, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2);
    issue(1, 4'd2, 32'h20, 32'h20, 2'd3);
    wait_idle("ovf");

    issue(3, 4'd5, 32'h1, 32'd4, 2'd1);
    issue(3, 4'd6, 32'h8000_0000, 32'd31, 2'd2);
    issue(3, 4'd5, 32'h3, 32'h25, 2'd3);
    wait_idle("shift");

    issue(0, 4'd3, 32'h11, 32'h22, 2'd2);
    issue(0, 4'hF, 32'h33, 32'h44, 2'd3);
    issue(0, 4'd0, 32'h55, 32'h0, 2'd1);
    wait_idle("invalid");

    for (int p = 0; p < 4; p++) issue(p, 4'd1, $urandom % 1000, $urandom % 1000, 2'(p));
    wait_idle("all_ports");
    issue(1, 4'd5, 32'h7, 32'd3, 2'd1);
    issue(0, 4'd1, 32'h7, 32'd3, 2'd2);
    wait_idle("mixed_units");

    for (int k = 0; k < 12; k++)
      for (int p = 0; p < 4; p++) issue(p, (p == 0) ? 4'd1 : 4'd2, $urandom, $urandom, 2'(k));
    wait_idle("full_queue");

    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 4; p++) issue(p, 4'd1, $urandom % 64, $urandom % 64, 2'(k));
    repeat (7) @(posedge c_clk);
    #2 reset = 1'b0;
    for (int p = 0; p < 4; p++) drvq[p].delete();
    #1;
    for (int p = 0; p < 4; p++) begin
      chk("async_rst_resp", p, 32'(resp_o[p]), 32'd0);
      chk("async_rst_data", p, dat_o[p], 32'd0);
    end
    repeat (2) @(posedge c_clk);
    #2 reset = 1'b1;
    wait_idle("after_reset");
    issue(0, 4'd1, 32'd5, 32'd6, 2'd2);
    wait_idle("first_after_reset");

    for (int n = 0; n < 500; n++) begin
      @(posedge c_clk); #3;
      for (int p = 0; p < 4; p++) begin
        if (drvq[p].size() == 0 && ($urandom % 3) == 0) begin
          a = $urandom;
          issue(p, rand_cmd(), a, ($urandom % 2) ? $urandom : ($urandom % 64), 2'($urandom));
        end
      end
    end
    wait_idle("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=running want=finished cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
